// File: rtl/r2fft_pkg.sv
// r2fft_pkg: FSM state type and width-parameterised bit-reverse helper shared by the FFT loader.
package r2fft_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  // Shifting the low w bits in LSB-first leaves them mirrored in r[w-1:0].
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (i < w) r = {r[30:0], v[i]};
    return r;
  endfunction
endpackage

// File: rtl/bitrev_loader_if.sv
// bitrev_loader_if: sample stream in, dpram write port and frame handshake out.
interface bitrev_loader_if #(parameter int ADDR_WIDTH = 9, parameter int DATA_WIDTH = 32);
  logic start, din_valid, din_ready, din_last, wact, frame_done, frame_ack, frame_err;
  logic [DATA_WIDTH-1:0] din, wdw;
  logic [ADDR_WIDTH-1:0] wa;
  modport master(output start, din_valid, din, din_last, frame_ack,
                 input din_ready, wact, wa, wdw, frame_done, frame_err);
  modport slave(input start, din_valid, din, din_last, frame_ack,
                output din_ready, wact, wa, wdw, frame_done, frame_err);
endinterface

// File: rtl/bitrev_loader.sv
// bitrev_loader: loads one N-sample frame into dpram; BITREV_LOADER_BITREV_EN selects bit-reversed write addresses.
module bitrev_loader
  import r2fft_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  bitrev_loader_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, wa_q, wa_d, addr;
  logic [DATA_WIDTH-1:0] wdw_q, wdw_d;
  logic wact_q, wact_d, err_q, err_d, accept, begin_load, is_last;
`ifdef BITREV_LOADER_BITREV_EN
  assign addr = ADDR_WIDTH'(bit_rev(32'(cnt_q), ADDR_WIDTH));
`else
  assign addr = cnt_q;
`endif
  always_comb begin
    accept = state_q == LOAD && bus.din_valid;
    begin_load = state_q == IDLE && bus.start;
    is_last = cnt_q == LAST;
    state_d = begin_load ? LOAD :
              (accept && is_last) ? FLUSH :
              state_q == FLUSH ? DONE :
              (state_q == DONE && bus.frame_ack) ? IDLE : state_q;
    cnt_d = begin_load ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
    // din_last must coincide exactly with sample N-1; any disagreement is sticky.
    err_d = begin_load ? 1'b0 : (accept && bus.din_last != is_last) ? 1'b1 : err_q;
    wact_d = accept;
    wa_d = accept ? addr : wa_q;
    wdw_d = accept ? bus.din : wdw_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wa_q <= '0;
      wdw_q <= '0;
      wact_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wa_q <= wa_d;
      wdw_q <= wdw_d;
      wact_q <= wact_d;
      err_q <= err_d;
    end
  end
  assign bus.din_ready = state_q == LOAD;
  assign bus.frame_done = state_q == DONE;
  assign bus.frame_err = err_q;
  assign bus.wact = wact_q;
  assign bus.wa = wa_q;
  assign bus.wdw = wdw_q;
endmodule

// File: doc/bitrev_loader.md
BITREV_LOADER -- requirements
Module: bitrev_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, RAM address width; frame length N = 2**ADDR_WIDTH samples.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, sample width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin loading one frame.
REQ-006 din_valid  input  1  upstream sample valid.
REQ-007 din_ready  output  1  loader accepts a sample this cycle.
REQ-008 din  input  DATA_WIDTH  sample data.
REQ-009 din_last  input  1  upstream marks the final sample of the frame.
REQ-010 wact  output  1  RAM write enable.
REQ-011 wa  output  ADDR_WIDTH  RAM write address.
REQ-012 wdw  output  DATA_WIDTH  RAM write data.
REQ-013 frame_done  output  1  complete frame resident in RAM; level, held until acknowledged.
REQ-014 frame_ack  input  1  consumer has finished with the frame.
REQ-015 frame_err  output  1  sticky framing error.

Function
REQ-016 SHALL implement states IDLE, LOAD, FLUSH, DONE.
REQ-017 Transitions: IDLE->LOAD on start; LOAD->FLUSH on acceptance of sample N-1; FLUSH->DONE unconditionally after one cycle; DONE->IDLE on frame_ack.
REQ-018 din_ready SHALL be 1 exactly when state==LOAD; a sample is accepted when din_valid && din_ready.
REQ-019 A sample counter SHALL clear to 0 on IDLE->LOAD and increment by 1 per accepted sample.
REQ-020 An accepted sample at cycle t SHALL produce wact=1, wa=addr(count), wdw=din, all registered and visible in cycle t+1; wact=0 in every other cycle.
REQ-021 frame_done SHALL be 1 only in DONE, i.e. two cycles after the final acceptance, so a consumer read never coincides with the final write.
REQ-022 start outside IDLE and frame_ack outside DONE SHALL be ignored.
REQ-023 frame_err SHALL set when din_last is 1 on an accepted sample other than N-1, or 0 on sample N-1; it SHALL clear on IDLE->LOAD.
REQ-024 An early din_last SHALL NOT terminate the frame; loading continues until N samples.
REQ-025 din_valid gaps in LOAD SHALL stall the counter with no write.

Reset
REQ-026 On rst: state=IDLE, counter=0, wact=0, wa=0, wdw=0, frame_done=0, frame_err=0, din_ready=0; reset mid-frame abandons the frame without further writes.

Configuration
REQ-027 With BITREV_LOADER_BITREV_EN defined, addr(count) SHALL be count bit-reversed over ADDR_WIDTH bits (radix-2 DIT input order).
REQ-028 Without BITREV_LOADER_BITREV_EN, addr(count) SHALL equal count (natural order); all other behaviour is identical.

Structure
REQ-029 The state enum typedef and a bit-reverse function parameterised on width SHALL live in package r2fft_pkg.
REQ-030 No sub-module SHALL be used; output registers drive the dpram write port directly.

Verification (ADDR_WIDTH=3, N=8, BITREV_LOADER_BITREV_EN defined unless stated)
REQ-031 start, then 8 back-to-back samples 0x10..0x17 with din_last on the 8th -> writes at wa 0,4,2,6,1,5,3,7 with data 0x10..0x17, frame_done=1 two cycles after the 8th acceptance, frame_err=0.
REQ-032 Same stimulus with the macro undefined -> wa 0..7 in order.
REQ-033 din_valid toggling 1,0,1,0 -> exactly one write per accepted sample; counter holds while din_valid=0; start pulsed during LOAD has no effect.
REQ-034 din_last on sample 3 -> frame_err=1, loading continues to 8 samples, frame_done asserts; the next start clears frame_err.
REQ-035 rst asserted after 5 accepted samples -> all outputs reach reset values immediately, with no further wact; a new start loads from wa=0.
REQ-036 Hold frame_done without frame_ack for 20 cycles -> frame_done stays 1 and din_ready stays 0; frame_ack -> IDLE next cycle, frame_done=0.
